// File: rtl/fp_cvt_w_s_if.sv
// Handshake and payload bundle for the binary32 to 32-bit integer converter.
interface fp_cvt_w_s_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_rm;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_nv;
  logic        out_nx;

  // Converter side
  modport slave (
    input  in_valid, in_data, in_rm, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_nv, out_nx
  );

  // Issue / writeback side
  modport master (
    output in_valid, in_data, in_rm, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_nv, out_nx
  );
endinterface

// File: rtl/fp_cvt_w_s.sv
// fcvt.w.s / fcvt.wu.s: binary32 to rounded, saturated 32-bit integer.
// Three stall-all stages: unpack, align, round+saturate (output register).
module fp_cvt_w_s (
  input logic         clk,
  input logic         rst_n,
  fp_cvt_w_s_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 24;
  localparam int unsigned EW = 10;
  localparam int unsigned RW = 3;
  localparam int unsigned AW = 33;
  localparam int unsigned XW = 64;

  localparam logic [DW-1:0] S_MAX = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] S_MIN = 32'h8000_0000;
  localparam logic [DW-1:0] U_MAX = 32'hFFFF_FFFF;

  logic advance;

  // Stage 1 state
  logic                 s1_valid, s1_sign, s1_uns, s1_nan;
  logic signed [EW-1:0] s1_e;
  logic [MW-1:0]        s1_mant;
  logic [RW-1:0]        s1_rm;

  // Stage 2 state
  logic          s2_valid, s2_sign, s2_uns, s2_nan, s2_ovf, s2_guard, s2_sticky;
  logic [AW-1:0] s2_mag;
  logic [RW-1:0] s2_rm;

  // Unpack combinational
  logic [7:0]           in_exp;
  logic signed [EW-1:0] in_e;

  // Align combinational
  logic [5:0]    sh;
  logic [XW-1:0] wide;
  logic          al_ovf, al_guard, al_sticky;
  logic [AW-1:0] al_mag;

  // Round/saturate combinational
  logic          inexact, inc;
  logic [AW-1:0] rmag;
  logic [DW-1:0] neg_mag, res_data;
  logic          res_nv, res_nx;

  // Whole pipe moves only when the output register can take a new value
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Unbiased exponent; subnormals and zero share e = -126 with hidden bit 0
  assign in_exp = bus.in_data[30:23];
  assign in_e   = (in_exp == 8'd0) ? EW'(-126) : $signed(EW'(in_exp) - EW'(127));

  // Stage 1: capture fields and classify
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_uns   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_e     <= '0;
      s1_mant  <= '0;
      s1_rm    <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= bus.in_data[31];
      s1_uns   <= bus.in_unsigned;
      s1_nan   <= (in_exp == 8'hFF) && (bus.in_data[22:0] != 23'd0);
      s1_e     <= in_e;
      s1_mant  <= {in_exp != 8'd0, bus.in_data[22:0]};
      s1_rm    <= bus.in_rm;
    end
  end

  // Fixed point with 32 fraction bits: value * 2^32 = mant << (e + 9), valid for 0 <= e <= 31
  assign sh   = s1_e[5:0] + 6'd9;
  assign wide = XW'(s1_mant) << sh;

  // Stage 2 combinational: magnitude, guard and sticky
  always_comb begin
    al_mag    = '0;
    al_guard  = 1'b0;
    al_sticky = 1'b0;
    // Inf/NaN land at e = 128, so the exponent test alone covers them
    al_ovf    = !s1_e[EW-1] && (s1_e[EW-2:5] != '0);
    if (!s1_e[EW-1] && !al_ovf) begin
      al_mag    = AW'(wide[XW-1:32]);
      al_guard  = wide[31];
      al_sticky = |wide[30:0];
    end else if (s1_e[EW-1]) begin
      al_guard  = (&s1_e) && s1_mant[MW-1];
      al_sticky = al_guard ? |s1_mant[MW-2:0] : |s1_mant;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_uns    <= 1'b0;
      s2_nan    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_mag    <= '0;
      s2_rm     <= '0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_uns    <= s1_uns;
      s2_nan    <= s1_nan;
      s2_ovf    <= al_ovf;
      s2_guard  <= al_guard;
      s2_sticky <= al_sticky;
      s2_mag    <= al_mag;
      s2_rm     <= s1_rm;
    end
  end

  // Stage 3 combinational: round, then range-check the rounded magnitude
  always_comb begin
    inexact  = s2_guard | s2_sticky;
    inc      = 1'b0;
    res_data = '0;
    res_nv   = 1'b0;
    res_nx   = 1'b0;
    case (s2_rm)
      3'b000:  inc = s2_guard & (s2_sticky | s2_mag[0]);
      3'b010:  inc = s2_sign & inexact;
      3'b011:  inc = !s2_sign & inexact;
      3'b100:  inc = s2_guard;
      default: inc = 1'b0;
    endcase
    rmag    = s2_mag + AW'(inc);
    neg_mag = (~rmag[DW-1:0]) + 32'd1;
    if (s2_ovf) begin
      res_nv = 1'b1;
      if (s2_nan || !s2_sign) res_data = s2_uns ? U_MAX : S_MAX;
      else                    res_data = s2_uns ? '0 : S_MIN;
    end else if (s2_uns) begin
      if (s2_sign && (rmag != '0)) begin
        res_nv = 1'b1;
      end else if (!s2_sign && rmag[AW-1]) begin
        res_nv   = 1'b1;
        res_data = U_MAX;
      end else begin
        res_data = s2_sign ? '0 : rmag[DW-1:0];
        res_nx   = inexact;
      end
    end else begin
      if (!s2_sign && (rmag > AW'(S_MAX))) begin
        res_nv   = 1'b1;
        res_data = S_MAX;
      end else if (s2_sign && (rmag > AW'(S_MIN))) begin
        res_nv   = 1'b1;
        res_data = S_MIN;
      end else begin
        res_data = s2_sign ? neg_mag : rmag[DW-1:0];
        res_nx   = inexact;
      end
    end
  end

  // Stage 3 / output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_nv    <= 1'b0;
      bus.out_nx    <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= s2_valid;
      bus.out_data  <= res_data;
      bus.out_nv    <= res_nv;
      bus.out_nx    <= res_nx;
    end
  end
endmodule
